axi4_lite_cmd_mst: RTL and testbench

AXI4_LITE_CMD_MST -- requirements
Module: axi4_lite_cmd_mst

---
 rtl/axi4_lite_cmd_mst_pkg.sv | 18 +
 rtl/axi4_lite_if.sv | 41 ++++
 rtl/axi4_lite_cmd_mst.sv | 174 +++++++++++++++++
 tb/tb_axi4_lite_cmd_mst.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_cmd_mst_pkg.sv
// Shared types and constants for the single-outstanding AXI4-Lite command master.
package axi4_lite_cmd_mst_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR_AW_W,
      WR_B,
      RD_AR,
      RD_R,
      RSP
   } state_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite channel bundle with master and slave views.
interface axi4_lite_if #(
   parameter int ADDR_BIT_WIDTH = 32,
   parameter int DATA_BIT_WIDTH = 32
);
   logic [ADDR_BIT_WIDTH-1:0]   awaddr;
   logic [2:0]                  awprot;
   logic                        awvalid;
   logic                        awready;
   logic [DATA_BIT_WIDTH-1:0]   wdata;
   logic [DATA_BIT_WIDTH/8-1:0] wstrb;
   logic                        wvalid;
   logic                        wready;
   logic [1:0]                  bresp;
   logic                        bvalid;
   logic                        bready;
   logic [ADDR_BIT_WIDTH-1:0]   araddr;
   logic [2:0]                  arprot;
   logic                        arvalid;
   logic                        arready;
   logic [DATA_BIT_WIDTH-1:0]   rdata;
   logic [1:0]                  rresp;
   logic                        rvalid;
   logic                        rready;

   modport mst_port (
      output awaddr, awprot, awvalid, input awready,
      output wdata, wstrb, wvalid, input wready,
      input bresp, bvalid, output bready,
      output araddr, arprot, arvalid, input arready,
      input rdata, rresp, rvalid, output rready
   );

   modport slv_port (
      input awaddr, awprot, awvalid, output awready,
      input wdata, wstrb, wvalid, output wready,
      output bresp, bvalid, input bready,
      input araddr, arprot, arvalid, output arready,
      output rdata, rresp, rvalid, input rready
   );
endinterface

// File: rtl/axi4_lite_cmd_mst.sv
// Single-outstanding AXI4-Lite master: one command becomes one AW+W/B or AR/R
// exchange, and the slave's answer is returned on a valid/ready response port.
module axi4_lite_cmd_mst
   import axi4_lite_cmd_mst_pkg::*;
#(
   parameter int ADDR_BIT_WIDTH = 32,
   parameter int DATA_BIT_WIDTH = 32
) (
   input  logic                        i_clk,
   input  logic                        i_sync_rst_n,
   input  logic                        i_cmd_valid,
   output logic                        o_cmd_ready,
   input  logic                        i_cmd_is_wr,
   input  logic [ADDR_BIT_WIDTH-1:0]   i_cmd_addr,
   input  logic [DATA_BIT_WIDTH-1:0]   i_cmd_wr_data,
   input  logic [DATA_BIT_WIDTH/8-1:0] i_cmd_wr_strb,
   output logic                        o_rsp_valid,
   input  logic                        i_rsp_ready,
   output logic                        o_rsp_is_wr,
   output logic [DATA_BIT_WIDTH-1:0]   o_rsp_rd_data,
   output logic [1:0]                  o_rsp_resp,
   output logic                        o_busy,
   axi4_lite_if.mst_port               if_m_axi4_lite
);

   localparam int STRB_W = DATA_BIT_WIDTH / 8;

   state_e                    state_q,     state_d;
   logic                      awvalid_q,   awvalid_d;
   logic                      wvalid_q,    wvalid_d;
   logic                      arvalid_q,   arvalid_d;
   logic                      bready_q,    bready_d;
   logic                      rready_q,    rready_d;
   logic                      is_wr_q,     is_wr_d;
   logic [ADDR_BIT_WIDTH-1:0] addr_q,      addr_d;
   logic [DATA_BIT_WIDTH-1:0] wdata_q,     wdata_d;
   logic [STRB_W-1:0]         wstrb_q,     wstrb_d;
   logic                      rsp_valid_q, rsp_valid_d;
   logic [DATA_BIT_WIDTH-1:0] rd_data_q,   rd_data_d;
   logic [1:0]                resp_q,      resp_d;
   logic                      aw_done,     w_done;

   // NOTE: every signal driven here gets its default first, so no path leaves one unassigned (no latch).
   always_comb begin
      state_d     = state_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      arvalid_d   = arvalid_q;
      bready_d    = bready_q;
      rready_d    = rready_q;
      is_wr_d     = is_wr_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      rsp_valid_d = rsp_valid_q;
      rd_data_d   = rd_data_q;
      resp_d      = resp_q;
      // A channel counts as done once its valid has dropped or it handshakes this cycle.
      aw_done     = !awvalid_q || if_m_axi4_lite.awready;
      w_done      = !wvalid_q  || if_m_axi4_lite.wready;

      case (state_q)
         IDLE: begin
            if (i_cmd_valid) begin
               is_wr_d = i_cmd_is_wr;
               addr_d  = i_cmd_addr;
               wdata_d = i_cmd_wr_data;
               wstrb_d = i_cmd_wr_strb;
               if (i_cmd_is_wr) begin
                  state_d   = WR_AW_W;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
               end else begin
                  state_d   = RD_AR;
                  arvalid_d = 1'b1;
               end
            end
         end
         WR_AW_W: begin
            awvalid_d = awvalid_q && !if_m_axi4_lite.awready;
            wvalid_d  = wvalid_q  && !if_m_axi4_lite.wready;
            if (aw_done && w_done) begin
               state_d  = WR_B;
               bready_d = 1'b1;
            end
         end
         WR_B: begin
            if (if_m_axi4_lite.bvalid && bready_q) begin
               bready_d    = 1'b0;
               rd_data_d   = '0;
               resp_d      = if_m_axi4_lite.bresp;
               rsp_valid_d = 1'b1;
               state_d     = RSP;
            end
         end
         RD_AR: begin
            if (if_m_axi4_lite.arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = RD_R;
            end
         end
         RD_R: begin
            if (if_m_axi4_lite.rvalid && rready_q) begin
               rready_d    = 1'b0;
               rd_data_d   = if_m_axi4_lite.rdata;
               resp_d      = if_m_axi4_lite.rresp;
               rsp_valid_d = 1'b1;
               state_d     = RSP;
            end
         end
         RSP: begin
            if (i_rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (!i_sync_rst_n) begin
         state_q     <= IDLE;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         bready_q    <= 1'b0;
         rready_q    <= 1'b0;
         is_wr_q     <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         rsp_valid_q <= 1'b0;
         rd_data_q   <= '0;
         resp_q      <= RESP_OKAY;
      end else begin
         state_q     <= state_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         arvalid_q   <= arvalid_d;
         bready_q    <= bready_d;
         rready_q    <= rready_d;
         is_wr_q     <= is_wr_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         rsp_valid_q <= rsp_valid_d;
         rd_data_q   <= rd_data_d;
         resp_q      <= resp_d;
      end
   end

   assign o_cmd_ready   = (state_q == IDLE);
   assign o_busy        = (state_q != IDLE);
   assign o_rsp_valid   = rsp_valid_q;
   assign o_rsp_is_wr   = is_wr_q;
   assign o_rsp_rd_data = rd_data_q;
   assign o_rsp_resp    = resp_q;

   assign if_m_axi4_lite.awaddr  = addr_q;
   assign if_m_axi4_lite.awprot  = 3'b000;
   assign if_m_axi4_lite.awvalid = awvalid_q;
   assign if_m_axi4_lite.wdata   = wdata_q;
   assign if_m_axi4_lite.wstrb   = wstrb_q;
   assign if_m_axi4_lite.wvalid  = wvalid_q;
   assign if_m_axi4_lite.bready  = bready_q;
   assign if_m_axi4_lite.araddr  = addr_q;
   assign if_m_axi4_lite.arprot  = 3'b000;
   assign if_m_axi4_lite.arvalid = arvalid_q;
   assign if_m_axi4_lite.rready  = rready_q;

endmodule

// File: tb/tb_axi4_lite_cmd_mst.sv
// Bench for axi4_lite_cmd_mst: table vectors, hold/reset sequences, and random traffic
// against a word-memory slave model with programmable ready/valid delays and responses.
module tb_axi4_lite_cmd_mst;
   import axi4_lite_cmd_mst_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid, cmd_ready, cmd_is_wr;
   logic [31:0] cmd_addr, cmd_wr_data;
   logic [3:0]  cmd_wr_strb;
   logic        rsp_valid, rsp_ready, rsp_is_wr, busy;
   logic [31:0] rsp_rd_data;
   logic [1:0]  rsp_resp;

   axi4_lite_if #(.ADDR_BIT_WIDTH(32), .DATA_BIT_WIDTH(32)) axi ();

   axi4_lite_cmd_mst #(.ADDR_BIT_WIDTH(32), .DATA_BIT_WIDTH(32)) dut (
      .i_clk          (clk),
      .i_sync_rst_n   (rst_n),
      .i_cmd_valid    (cmd_valid),
      .o_cmd_ready    (cmd_ready),
      .i_cmd_is_wr    (cmd_is_wr),
      .i_cmd_addr     (cmd_addr),
      .i_cmd_wr_data  (cmd_wr_data),
      .i_cmd_wr_strb  (cmd_wr_strb),
      .o_rsp_valid    (rsp_valid),
      .i_rsp_ready    (rsp_ready),
      .o_rsp_is_wr    (rsp_is_wr),
      .o_rsp_rd_data  (rsp_rd_data),
      .o_rsp_resp     (rsp_resp),
      .o_busy         (busy),
      .if_m_axi4_lite (axi)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // ---------------- slave model (acts on the falling edge) ----------------
   int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
   logic [1:0]  sl_resp;
   logic [31:0] mem [256];
   bit          have_aw, have_w, b_pend, r_pend;
   int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
   bit          aw_hs, w_hs, b_hs, ar_hs, r_hs;
   bit          rst_seen = 1'b1;
   logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
   logic [3:0]  cap_wstrb;
   logic [31:0] log_awaddr, log_wdata, log_araddr;
   logic [3:0]  log_wstrb;
   int          n_aw, n_w, n_b, n_ar, n_r;
   int          viol = 0;
   bit          p_aw, p_w, p_ar;
   logic [31:0] p_awaddr, p_wdata, p_araddr;
   logic [3:0]  p_wstrb;

   always @(negedge clk) begin
      if (rst_seen) begin
         have_aw = 0; have_w = 0; b_pend = 0; r_pend = 0;
         aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
         axi.awready = 0; axi.wready = 0; axi.arready = 0; axi.bvalid = 0; axi.rvalid = 0;
         axi.bresp = 0; axi.rresp = 0; axi.rdata = 0;
         p_aw = 0; p_w = 0; p_ar = 0;
      end else begin
         // Valid must stay up with a frozen payload until its handshake; nothing new during a response.
         if (p_aw && !aw_hs && (!axi.awvalid || axi.awaddr !== p_awaddr)) viol++;
         if (p_w && !w_hs && (!axi.wvalid || axi.wdata !== p_wdata || axi.wstrb !== p_wstrb)) viol++;
         if (p_ar && !ar_hs && (!axi.arvalid || axi.araddr !== p_araddr)) viol++;
         if (rsp_valid && (axi.awvalid || axi.wvalid || axi.arvalid)) viol++;
         if (axi.awprot !== 3'b000 || axi.arprot !== 3'b000) viol++;

         if (aw_hs) begin have_aw = 1; log_awaddr = cap_awaddr; n_aw++; end
         if (w_hs) begin have_w = 1; log_wdata = cap_wdata; log_wstrb = cap_wstrb; n_w++; end
         if (b_hs) begin b_pend = 0; n_b++; end
         if (r_hs) begin r_pend = 0; n_r++; end
         if (ar_hs) begin
            r_pend = 1; r_cnt = 0; log_araddr = cap_araddr; n_ar++;
            axi.rdata = mem[cap_araddr[9:2]];
            axi.rresp = sl_resp;
         end
         if (have_aw && have_w && !b_pend) begin
            for (int i = 0; i < 4; i++)
               if (log_wstrb[i]) mem[log_awaddr[9:2]][8*i +: 8] = log_wdata[8*i +: 8];
            b_pend = 1; b_cnt = 0; have_aw = 0; have_w = 0;
            axi.bresp = sl_resp;
         end

         axi.awready = axi.awvalid && !have_aw && (aw_cnt >= aw_dly);
         aw_cnt      = (axi.awvalid && !axi.awready) ? aw_cnt + 1 : 0;
         axi.wready  = axi.wvalid && !have_w && (w_cnt >= w_dly);
         w_cnt       = (axi.wvalid && !axi.wready) ? w_cnt + 1 : 0;
         axi.arready = axi.arvalid && !r_pend && (ar_cnt >= ar_dly);
         ar_cnt      = (axi.arvalid && !axi.arready) ? ar_cnt + 1 : 0;
         axi.bvalid  = b_pend && (b_cnt >= b_dly);
         if (b_pend && !axi.bvalid) b_cnt++;
         axi.rvalid  = r_pend && (r_cnt >= r_dly);
         if (r_pend && !axi.rvalid) r_cnt++;

         p_aw = axi.awvalid; p_awaddr = axi.awaddr;
         p_w  = axi.wvalid;  p_wdata  = axi.wdata; p_wstrb = axi.wstrb;
         p_ar = axi.arvalid; p_araddr = axi.araddr;
      end
      aw_hs = rst_n && axi.awvalid && axi.awready;
      w_hs  = rst_n && axi.wvalid && axi.wready;
      b_hs  = rst_n && axi.bvalid && axi.bready;
      ar_hs = rst_n && axi.arvalid && axi.arready;
      r_hs  = rst_n && axi.rvalid && axi.rready;
      cap_awaddr = axi.awaddr; cap_wdata = axi.wdata; cap_wstrb = axi.wstrb; cap_araddr = axi.araddr;
      rst_seen = !rst_n;
   end

   // ---------------- command-side helpers ----------------
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output bit ok);
      int n = 0;
      n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0;
      cmd_valid = 1; cmd_is_wr = wr; cmd_addr = a; cmd_wr_data = d; cmd_wr_strb = s;
      while (!cmd_ready && n < 100) begin cycle(); n++; end
      ok = cmd_ready;
      cycle();
      cmd_valid = 0; cmd_addr = $urandom; cmd_wr_data = $urandom; cmd_wr_strb = 4'($urandom);
   endtask

   task automatic wait_rsp(output int lat, output bit ok);
      lat = 1;
      while (!rsp_valid && lat < 300) begin cycle(); lat++; end
      ok = rsp_valid;
   endtask

   task automatic ack_rsp();
      rsp_ready = 1;
      cycle();
      rsp_ready = 0;
   endtask

   task automatic run_txn(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int hold, output logic r_wr,
                          output logic [31:0] r_data, output logic [1:0] r_resp, output int lat);
      bit acc_ok, rsp_ok;
      issue(wr, a, d, s, acc_ok);
      wait_rsp(lat, rsp_ok);
      check("txn_handshake", {acc_ok, rsp_ok}, 2'b11);
      r_wr = rsp_is_wr; r_data = rsp_rd_data; r_resp = rsp_resp;
      for (int k = 0; k < hold; k++) cycle();
      ack_rsp();
   endtask

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [1:0]  sresp;
      int          aw_d, w_d, b_d, ar_d, r_d;
      logic [31:0] exp_data;
      logic [1:0]  exp_resp;
      int          exp_lat;   // 0: latency not checked for this vector
   } vec_t;

   vec_t vecs [9];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic        g_wr, r_wr;
      logic [31:0] g_data, hold_data, a, d, exp_data;
      logic [31:0] mask;
      logic [1:0]  g_resp, hold_resp, sresp;
      logic [3:0]  s;
      logic [31:0] ref_mem [8];
      int          lat, bad, n, idx, hold;
      bit          ok, ok2;

      vecs[0] = '{1'b1, 32'h0000_0004, 32'hDEADBEEF, 4'hF, RESP_OKAY,   0, 0, 0, 0, 0, 32'h0,        RESP_OKAY,   3};
      vecs[1] = '{1'b0, 32'h0000_0004, 32'h0,        4'h0, RESP_OKAY,   0, 0, 0, 0, 0, 32'hDEADBEEF, RESP_OKAY,   3};
      vecs[2] = '{1'b0, 32'h0000_0008, 32'h0,        4'h0, RESP_SLVERR, 0, 0, 0, 0, 0, 32'h12345678, RESP_SLVERR, 3};
      vecs[3] = '{1'b1, 32'h0000_0008, 32'hAABBCCDD, 4'h5, RESP_OKAY,   0, 3, 0, 0, 0, 32'h0,        RESP_OKAY,   0};
      vecs[4] = '{1'b0, 32'h0000_0008, 32'h0,        4'h0, RESP_OKAY,   0, 0, 0, 0, 0, 32'h12BB56DD, RESP_OKAY,   3};
      vecs[5] = '{1'b1, 32'h0000_000C, 32'h01020304, 4'hF, RESP_DECERR, 0, 0, 0, 0, 0, 32'h0,        RESP_DECERR, 3};
      vecs[6] = '{1'b0, 32'h0000_000C, 32'h0,        4'h0, RESP_EXOKAY, 0, 0, 0, 2, 2, 32'h01020304, RESP_EXOKAY, 0};
      vecs[7] = '{1'b1, 32'h0000_0010, 32'h55AA55AA, 4'hC, RESP_SLVERR, 2, 0, 2, 0, 0, 32'h0,        RESP_SLVERR, 0};
      vecs[8] = '{1'b0, 32'h0000_0010, 32'h0,        4'h0, RESP_OKAY,   0, 0, 0, 0, 0, 32'h55AA0000, RESP_OKAY,   3};

      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[2] = 32'h12345678;
      cmd_valid = 0; cmd_is_wr = 0; cmd_addr = 0; cmd_wr_data = 0; cmd_wr_strb = 0; rsp_ready = 0;
      axi.awready = 0; axi.wready = 0; axi.arready = 0; axi.bvalid = 0; axi.rvalid = 0;
      axi.bresp = 0; axi.rresp = 0; axi.rdata = 0;
      aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0; sl_resp = RESP_OKAY;

      // Reset state
      repeat (3) cycle();
      check("reset_ctrl", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready,
                           rsp_valid, rsp_is_wr, busy}, 8'h00);
      check("reset_rsp_fields", {rsp_rd_data, rsp_resp}, 34'h0);
      check("reset_payloads", {axi.awaddr, axi.wdata, axi.wstrb}, 68'h0);
      rst_n = 1;
      cycle();
      check("cmd_ready_after_release", {cmd_ready, busy}, 2'b10);

      // Table vectors
      foreach (vecs[i]) begin
         aw_dly = vecs[i].aw_d; w_dly = vecs[i].w_d; b_dly = vecs[i].b_d;
         ar_dly = vecs[i].ar_d; r_dly = vecs[i].r_d; sl_resp = vecs[i].sresp;
         run_txn(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].strb, 0, g_wr, g_data, g_resp, lat);
         check($sformatf("v%0d_is_wr", i), g_wr, vecs[i].wr);
         check($sformatf("v%0d_rd_data", i), g_data, vecs[i].exp_data);
         check($sformatf("v%0d_resp", i), g_resp, vecs[i].exp_resp);
         if (vecs[i].exp_lat != 0) check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
         if (vecs[i].wr) begin
            check($sformatf("v%0d_hs_counts", i), {8'(n_aw), 8'(n_w), 8'(n_b), 8'(n_ar), 8'(n_r)}, 40'h01_01_01_00_00);
            check($sformatf("v%0d_aw_w_beat", i), {log_awaddr, log_wdata}, {vecs[i].addr, vecs[i].data});
            check($sformatf("v%0d_wstrb", i), log_wstrb, vecs[i].strb);
         end else begin
            check($sformatf("v%0d_hs_counts", i), {8'(n_aw), 8'(n_w), 8'(n_b), 8'(n_ar), 8'(n_r)}, 40'h00_00_00_01_01);
            check($sformatf("v%0d_araddr", i), log_araddr, vecs[i].addr);
         end
      end
      aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0; sl_resp = RESP_OKAY;

      // Response held off for 5 cycles while a second command waits
      issue(1'b0, 32'h0000_0004, 32'h0, 4'h0, ok);
      wait_rsp(lat, ok2);
      check("hold_rsp_seen", {ok, ok2}, 2'b11);
      hold_data = rsp_rd_data; hold_resp = rsp_resp;
      check("hold_rd_data", {hold_data, hold_resp}, {32'hDEADBEEF, RESP_OKAY});
      cmd_valid = 1; cmd_is_wr = 1; cmd_addr = 32'h14; cmd_wr_data = 32'hCAFEF00D; cmd_wr_strb = 4'hF;
      bad = 0;
      for (int k = 0; k < 5; k++) begin
         if (rsp_valid !== 1'b1 || rsp_rd_data !== hold_data || rsp_resp !== hold_resp ||
             rsp_is_wr !== 1'b0 || cmd_ready !== 1'b0 || axi.awvalid || axi.wvalid || axi.arvalid) bad++;
         cycle();
      end
      check("hold_stable_cycles", bad, 0);
      ack_rsp();
      check("after_rsp_ack", {cmd_ready, rsp_valid, axi.awvalid, axi.wvalid, axi.arvalid}, 5'b10000);
      n_aw = 0; n_w = 0; n_b = 0;
      cycle();
      cmd_valid = 0;
      check("second_cmd_start", {axi.awvalid, axi.wvalid, cmd_ready}, 3'b110);
      wait_rsp(lat, ok2);
      check("second_cmd_rsp", {ok2, rsp_is_wr, rsp_rd_data, rsp_resp}, {1'b1, 1'b1, 32'h0, RESP_OKAY});
      ack_rsp();

      // Reset while waiting for B
      b_dly = 6;
      issue(1'b1, 32'h0000_0018, 32'h11112222, 4'hF, ok);
      n = 0;
      while (!axi.bready && n < 20) begin cycle(); n++; end
      check("reached_wr_b", {ok, axi.bready, axi.awvalid, axi.wvalid}, 4'b1100);
      rst_n = 0;
      cycle();
      check("mid_rst_ctrl", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready,
                             rsp_valid, rsp_is_wr, busy}, 8'h00);
      check("mid_rst_rsp_fields", {rsp_rd_data, rsp_resp}, 34'h0);
      rst_n = 1; b_dly = 0;
      cycle();
      check("mid_rst_cmd_ready", {cmd_ready, busy}, 2'b10);
      n = 0;
      repeat (8) begin
         if (rsp_valid || axi.bready) n++;
         cycle();
      end
      check("abandoned_no_rsp", n, 0);

      // Fill 8 words with a pattern and read them back
      for (int i = 0; i < 8; i++) begin
         ref_mem[i] = 32'hA5A5_0000 + 32'(i);
         run_txn(1'b1, 32'(i) << 2, ref_mem[i], 4'hF, 0, g_wr, g_data, g_resp, lat);
         check($sformatf("fill%0d_wr_rsp", i), {g_wr, g_data, g_resp}, {1'b1, 32'h0, RESP_OKAY});
      end
      for (int i = 0; i < 8; i++) begin
         run_txn(1'b0, 32'(i) << 2, 32'h0, 4'h0, 0, g_wr, g_data, g_resp, lat);
         check($sformatf("readback%0d", i), {g_wr, g_data, g_resp}, {1'b0, ref_mem[i], RESP_OKAY});
      end

      // Random traffic against the word-memory model
      for (int t = 0; t < 40; t++) begin
         r_wr = 1'($urandom);
         idx = $urandom_range(0, 7);
         a = 32'(idx) << 2;
         d = $urandom;
         s = 4'($urandom);
         sresp = 2'($urandom);
         hold = $urandom_range(0, 2);
         aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
         ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3); sl_resp = sresp;
         if (r_wr) begin
            mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
            ref_mem[idx] = (ref_mem[idx] & ~mask) | (d & mask);
            exp_data = 32'h0;
         end else begin
            exp_data = ref_mem[idx];
         end
         run_txn(r_wr, a, d, s, hold, g_wr, g_data, g_resp, lat);
         check($sformatf("rand%0d_rsp", t), {g_wr, g_data, g_resp}, {r_wr, exp_data, sresp});
      end

      check("protocol_violations", viol, 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
